dual_issue_ctrl: RTL and testbench
==================================

DUAL_ISSUE_CTRL -- requirements
Module: dual_issue_ctrl

Interface
REQ-001 SHALL have parameter INS_WIDTH, default 32, instruction word width.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port fetch_valid  input  1  fetch presents an instruction pair.
REQ-005 SHALL have port fetch_ins_1 / fetch_ins_2  input  INS_WIDTH each  older / younger instruction of the pair.
REQ-006 SHALL have port fetch_ready  output  1  block accepts the pair this cycle.
REQ-007 SHALL have port both_stall / single_stall  input  1 each  stall verdicts from the dependence checker for the held pair.
REQ-008 SHALL have port cand_ins_1 / cand_ins_2  output  INS_WIDTH each  held pair presented to decode/dependence check (combinational from holding registers).
REQ-009 SHALL have port cand_valid_1 / cand_valid_2  output  1 each  slot holds a pending instruction.
REQ-010 SHALL have port single_stall_reg  output  1  high while only the younger instruction remains pending.
REQ-011 SHALL have port issue_valid_1 / issue_valid_2  output  1 each  registered issue strobe per pipe.
REQ-012 SHALL have port issue_ins_1 / issue_ins_2  output  INS_WIDTH each  registered issued instruction; zero when invalid (NOP).

Function
REQ-013 SHALL implement FSM states EMPTY, PAIR, SECOND; single_stall_reg = (state==SECOND).
REQ-014 SHALL assert fetch_ready in EMPTY, and in PAIR/SECOND only in a cycle whose held contents fully issue.
REQ-015 SHALL load both fetch words into holding registers on fetch_valid && fetch_ready and enter PAIR next cycle.
REQ-016 SHALL, in PAIR: both_stall -> hold, no issue; else single_stall -> issue slot 1 on pipe 1, NOP on pipe 2, go SECOND; else issue both, then PAIR if a new pair accepted, otherwise EMPTY.
REQ-017 SHALL, in SECOND: cand_valid_1=0, cand_ins_1=0, cand_valid_2=1; either stall -> hold; else issue slot 2 on pipe 2, NOP on pipe 1, then PAIR if a new pair accepted, otherwise EMPTY.
REQ-018 SHALL give both_stall priority over single_stall when both asserted.
REQ-019 SHALL ignore both_stall/single_stall in EMPTY and issue NOPs there.
REQ-020 SHALL register issue outputs: decision in cycle N appears on issue_* in cycle N+1; every non-issuing cycle drives issue_valid_*=0, issue_ins_*=0.
REQ-021 SHALL issue every accepted instruction exactly once, in order, slot 1 never after slot 2.
REQ-022 SHALL keep fetch_ins_* ignored when fetch_ready=0 (no buffering beyond one pair).

Reset
REQ-023 SHALL on reset assertion immediately enter EMPTY, clear holding registers, cand_*, issue_valid_*, issue_ins_*, single_stall_reg to 0; fetch_ready=1 after reset.
REQ-024 SHALL drop a pair held at reset mid-operation without issuing it.

Configuration
REQ-025 SHALL, with macro DUAL_ISSUE_STATS_EN defined, add outputs stat_both_stall, stat_single_stall, stat_issued (16 bits each, saturating at 16'hFFFF, reset to 0) counting PAIR/SECOND cycles with both_stall, PAIR cycles taking the single_stall path, and instructions issued.
REQ-026 SHALL, without DUAL_ISSUE_STATS_EN, have neither those ports nor counters; all other behaviour identical.

Verification
REQ-027 SHALL cover: pair A1/A2 accepted, no stalls -> next cycle issue_valid_1=issue_valid_2=1 with A1/A2, fetch_ready=1 throughout back-to-back pairs.
REQ-028 SHALL cover: single_stall=1 in PAIR -> pipe 1 issues A1, pipe 2 NOP, single_stall_reg=1, fetch_ready=0; next cycle no stall -> pipe 2 issues A2, single_stall_reg=0.
REQ-029 SHALL cover: both_stall=1 for 3 cycles in PAIR -> 3 cycles of NOPs, cand_ins unchanged, then both issue.
REQ-030 SHALL cover: both_stall=1 and single_stall=1 together -> treated as both_stall, nothing issues.
REQ-031 SHALL cover: reset asserted asynchronously while in SECOND -> all outputs 0 before next clk edge, held A2 never issued.
REQ-032 SHALL cover (DUAL_ISSUE_STATS_EN): 70000 consecutive both_stall cycles -> stat_both_stall saturates at 65535.

Source files
------------

// File: rtl/dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl
// Purpose  : Holds one fetched instruction pair and issues it in order to two
//            pipes, splitting the pair when the dependence checker says so.
//            Optional counters enabled by macro DUAL_ISSUE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl #(
  parameter int INS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [INS_WIDTH-1:0] fetch_ins_1,
  input  logic [INS_WIDTH-1:0] fetch_ins_2,
  output logic                 fetch_ready,
  input  logic                 both_stall,
  input  logic                 single_stall,
  output logic [INS_WIDTH-1:0] cand_ins_1,
  output logic [INS_WIDTH-1:0] cand_ins_2,
  output logic                 cand_valid_1,
  output logic                 cand_valid_2,
  output logic                 single_stall_reg,
  output logic                 issue_valid_1,
  output logic                 issue_valid_2,
  output logic [INS_WIDTH-1:0] issue_ins_1,
  output logic [INS_WIDTH-1:0] issue_ins_2
`ifdef DUAL_ISSUE_STATS_EN
  ,
  output logic [15:0]          stat_both_stall,
  output logic [15:0]          stat_single_stall,
  output logic [15:0]          stat_issued
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PAIR   = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [INS_WIDTH-1:0]   ins1_q, ins1_d;
  logic [INS_WIDTH-1:0]   ins2_q, ins2_d;
  logic                   iss1_d, iss2_d;
  logic                   accept_w;
  logic [INS_WIDTH-1:0]   issue_ins_1_d, issue_ins_2_d;

  always_comb begin
    state_d     = state_q;
    fetch_ready = 1'b0;
    iss1_d      = 1'b0;
    iss2_d      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        // Stall verdicts are meaningless without a held pair.
        fetch_ready = 1'b1;
        if (fetch_valid) state_d = ST_PAIR;
      end
      ST_PAIR: begin
        if (both_stall) begin
          state_d = ST_PAIR;
        end else if (single_stall) begin
          iss1_d  = 1'b1;
          state_d = ST_SECOND;
        end else begin
          iss1_d      = 1'b1;
          iss2_d      = 1'b1;
          fetch_ready = 1'b1;
          state_d     = fetch_valid ? ST_PAIR : ST_EMPTY;
        end
      end
      ST_SECOND: begin
        if (!both_stall && !single_stall) begin
          iss2_d      = 1'b1;
          fetch_ready = 1'b1;
          state_d     = fetch_valid ? ST_PAIR : ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign accept_w      = fetch_valid && fetch_ready;
  assign ins1_d        = accept_w ? fetch_ins_1 : ins1_q;
  assign ins2_d        = accept_w ? fetch_ins_2 : ins2_q;
  assign issue_ins_1_d = iss1_d ? ins1_q : '0;
  assign issue_ins_2_d = iss2_d ? ins2_q : '0;

  assign cand_valid_1     = (state_q == ST_PAIR);
  assign cand_valid_2     = (state_q != ST_EMPTY);
  assign cand_ins_1       = cand_valid_1 ? ins1_q : '0;
  assign cand_ins_2       = cand_valid_2 ? ins2_q : '0;
  assign single_stall_reg = (state_q == ST_SECOND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      ins1_q        <= '0;
      ins2_q        <= '0;
      issue_valid_1 <= 1'b0;
      issue_valid_2 <= 1'b0;
      issue_ins_1   <= '0;
      issue_ins_2   <= '0;
    end else begin
      state_q       <= state_d;
      ins1_q        <= ins1_d;
      ins2_q        <= ins2_d;
      issue_valid_1 <= iss1_d;
      issue_valid_2 <= iss2_d;
      issue_ins_1   <= issue_ins_1_d;
      issue_ins_2   <= issue_ins_2_d;
    end
  end

`ifdef DUAL_ISSUE_STATS_EN
  logic [16:0] issued_sum_w;
  logic        both_evt_w;
  logic        single_evt_w;

  assign both_evt_w   = (state_q != ST_EMPTY) && both_stall;
  assign single_evt_w = (state_q == ST_PAIR) && !both_stall && single_stall;
  // A pair can add two at once, so clamp through a 17-bit sum.
  assign issued_sum_w = {1'b0, stat_issued} + {15'd0, iss1_d} + {15'd0, iss2_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_both_stall   <= 16'd0;
      stat_single_stall <= 16'd0;
      stat_issued       <= 16'd0;
    end else begin
      if (both_evt_w && stat_both_stall != 16'hFFFF)
        stat_both_stall <= stat_both_stall + 16'd1;
      if (single_evt_w && stat_single_stall != 16'hFFFF)
        stat_single_stall <= stat_single_stall + 16'd1;
      stat_issued <= issued_sum_w[16] ? 16'hFFFF : issued_sum_w[15:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_issue_ctrl
// Purpose  : Directed plus random bench for dual_issue_ctrl against a
//            pending-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_issue_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_valid;
  logic [W-1:0] fetch_ins_1, fetch_ins_2;
  logic         fetch_ready;
  logic         both_stall, single_stall;
  logic [W-1:0] cand_ins_1, cand_ins_2;
  logic         cand_valid_1, cand_valid_2, single_stall_reg;
  logic         issue_valid_1, issue_valid_2;
  logic [W-1:0] issue_ins_1, issue_ins_2;
`ifdef DUAL_ISSUE_STATS_EN
  logic [15:0]  stat_both_stall, stat_single_stall, stat_issued;
  int           m_sb, m_ss, m_iss;
`endif

  int tests = 0;
  int fails = 0;

  // Model: in-order queue of instructions still waiting to issue.
  logic [W-1:0] pend[$];
  logic         e_v1, e_v2;
  logic [W-1:0] e_i1, e_i2;

  dual_issue_ctrl #(.INS_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .fetch_ins_1(fetch_ins_1), .fetch_ins_2(fetch_ins_2),
    .fetch_ready(fetch_ready), .both_stall(both_stall),
    .single_stall(single_stall), .cand_ins_1(cand_ins_1),
    .cand_ins_2(cand_ins_2), .cand_valid_1(cand_valid_1),
    .cand_valid_2(cand_valid_2), .single_stall_reg(single_stall_reg),
    .issue_valid_1(issue_valid_1), .issue_valid_2(issue_valid_2),
    .issue_ins_1(issue_ins_1), .issue_ins_2(issue_ins_2)
`ifdef DUAL_ISSUE_STATS_EN
    , .stat_both_stall(stat_both_stall), .stat_single_stall(stat_single_stall),
    .stat_issued(stat_issued)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = pend.size();
    check({tag, ".fetch_ready"}, W'(fetch_ready), W'(n == 0 || (!both_stall && !single_stall)));
    check({tag, ".ssr"},         W'(single_stall_reg), W'(n == 1));
    check({tag, ".cv1"},         W'(cand_valid_1), W'(n == 2));
    check({tag, ".cv2"},         W'(cand_valid_2), W'(n != 0));
    check({tag, ".ci1"},         cand_ins_1, (n == 2) ? pend[0] : '0);
    check({tag, ".ci2"},         cand_ins_2, (n == 2) ? pend[1] : (n == 1) ? pend[0] : '0);
    check({tag, ".iv1"},         W'(issue_valid_1), W'(e_v1));
    check({tag, ".iv2"},         W'(issue_valid_2), W'(e_v2));
    check({tag, ".ii1"},         issue_ins_1, e_i1);
    check({tag, ".ii2"},         issue_ins_2, e_i2);
  endtask

  // One clock: drive inputs, check everything, then advance the model.
  task automatic step(input string tag, input logic fv, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic bs, input logic ss);
    int           n;
    logic         rdy, nv1, nv2;
    logic [W-1:0] ni1, ni2;
    @(negedge clk);
    fetch_valid = fv; fetch_ins_1 = a; fetch_ins_2 = b;
    both_stall = bs; single_stall = ss;
    #1;
    check_all(tag);
    n = pend.size();
    rdy = (n == 0) || (!bs && !ss);
    nv1 = 1'b0; nv2 = 1'b0; ni1 = '0; ni2 = '0;
    if (n == 2 && !bs) begin
      nv1 = 1'b1; ni1 = pend.pop_front();
      if (!ss) begin nv2 = 1'b1; ni2 = pend.pop_front(); end
    end else if (n == 1 && !bs && !ss) begin
      nv2 = 1'b1; ni2 = pend.pop_front();
    end
`ifdef DUAL_ISSUE_STATS_EN
    if (n > 0 && bs) m_sb++;
    if (n == 2 && !bs && ss) m_ss++;
    m_iss += int'(nv1) + int'(nv2);
`endif
    if (rdy && fv) begin pend.push_back(a); pend.push_back(b); end
    @(posedge clk);
    e_v1 = nv1; e_v2 = nv2; e_i1 = ni1; e_i2 = ni2;
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_ins_1 = '0; fetch_ins_2 = '0;
    both_stall = 1'b0; single_stall = 1'b0;
    e_v1 = 1'b0; e_v2 = 1'b0; e_i1 = '0; e_i2 = '0;
`ifdef DUAL_ISSUE_STATS_EN
    m_sb = 0; m_ss = 0; m_iss = 0;
`endif
    #1;
    check_all("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Back-to-back pairs, no stalls.
    step("b2b0", 1, 32'hA1, 32'hA2, 0, 0);
    step("b2b1", 1, 32'hB1, 32'hB2, 0, 0);
    step("b2b2", 1, 32'hC1, 32'hC2, 0, 0);
    step("b2b3", 0, 32'h0,  32'h0,  0, 0);
    step("b2b4", 0, 32'h0,  32'h0,  0, 0);

    // Pair split by single_stall; fetch attempt ignored while not ready.
    step("sp0", 1, 32'hD1, 32'hD2, 0, 0);
    step("sp1", 1, 32'hEE, 32'hEF, 0, 1);
    step("sp2", 1, 32'hF1, 32'hF2, 0, 0);
    step("sp3", 0, 32'h0,  32'h0,  0, 0);
    step("sp4", 0, 32'h0,  32'h0,  0, 0);

    // Three both_stall cycles, then both + single together, then release.
    step("bs0", 1, 32'h11, 32'h22, 0, 0);
    for (int i = 0; i < 3; i++) step("bs_hold", 1, 32'h99, 32'h98, 1, 0);
    step("bs_pri", 0, 32'h0, 32'h0, 1, 1);
    step("bs_rel", 0, 32'h0, 32'h0, 0, 0);
    step("bs_end", 0, 32'h0, 32'h0, 0, 0);

    // Stalls in SECOND hold the younger instruction.
    step("sec0", 1, 32'h31, 32'h32, 0, 0);
    step("sec1", 0, 32'h0,  32'h0,  0, 1);
    step("sec2", 0, 32'h0,  32'h0,  1, 0);
    step("sec3", 0, 32'h0,  32'h0,  0, 1);
    step("sec4", 1, 32'h41, 32'h42, 0, 0);
    step("sec5", 0, 32'h0,  32'h0,  0, 0);
    step("sec6", 0, 32'h0,  32'h0,  0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rnd", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
    step("drain0", 0, 32'h0, 32'h0, 0, 0);
    step("drain1", 0, 32'h0, 32'h0, 0, 0);
    step("drain2", 0, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset while in SECOND drops the held younger instruction.
    step("ar0", 1, 32'h51, 32'h52, 0, 0);
    step("ar1", 0, 32'h0,  32'h0,  0, 1);
    @(negedge clk);
    both_stall = 1'b0; single_stall = 1'b0;
    #2 reset = 1'b1;
    #1;
    pend.delete();
    e_v1 = 1'b0; e_v2 = 1'b0; e_i1 = '0; e_i2 = '0;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
`ifdef DUAL_ISSUE_STATS_EN
    m_sb = 0; m_ss = 0; m_iss = 0;
`endif
    step("post0", 0, 32'h0, 32'h0, 0, 0);
    step("post1", 0, 32'h0, 32'h0, 0, 0);
    step("post2", 1, 32'h61, 32'h62, 0, 1);
    step("post3", 0, 32'h0,  32'h0,  0, 0);
    step("post4", 0, 32'h0,  32'h0,  0, 0);
    step("post5", 0, 32'h0,  32'h0,  0, 0);

`ifdef DUAL_ISSUE_STATS_EN
    check("stat_ss", W'(stat_single_stall), W'(m_ss));
    check("stat_iss", W'(stat_issued), W'(m_iss));
    step("sat0", 1, 32'h71, 32'h72, 0, 0);
    step("sat1", 0, 32'h0,  32'h0,  1, 0);
    for (int i = 1; i < 70000; i++) begin
      @(negedge clk);
      both_stall = 1'b1; single_stall = 1'b0; fetch_valid = 1'b0;
      m_sb++;
    end
    @(negedge clk);
    #1;
    check("stat_bs_sat", W'(stat_both_stall), W'((m_sb > 65535) ? 65535 : m_sb));
    check("stat_bs_abs", W'(stat_both_stall), W'(16'hFFFF));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
